// File: rtl/data_bus_bridge.sv
// Multi-cycle bridge from the MEM-stage RAM port to a word-wide req/ack bus.
// One access in flight: the request is latched, held until ack/err/timeout, and the pipeline is stalled.
module data_bus_bridge #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        stall_req_o,
  output logic        err_o,
  output logic        err_sticky_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        we_reg, we_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_flag_reg, err_flag_next;
  logic        sticky_reg, sticky_next;

  logic start;
  logic addr_lsb_unused;

  // The bus is word-addressed; the byte offset is conveyed by the lane selects.
  assign addr_lsb_unused = ^ram_addr_i[1:0];
  assign start = ram_ce_i && (ram_sel_i != 4'b0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      we_reg       <= 1'b0;
      sel_reg      <= 4'b0000;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      rdata_reg    <= 32'd0;
      err_flag_reg <= 1'b0;
      sticky_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      we_reg       <= we_next;
      sel_reg      <= sel_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      err_flag_reg <= err_flag_next;
      sticky_reg   <= sticky_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    we_next       = we_reg;
    sel_next      = sel_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    err_flag_next = err_flag_reg;
    sticky_next   = sticky_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          we_next    = ram_we_i;
          sel_next   = ram_sel_i;
          addr_next  = {ram_addr_i[31:2], 2'b00};
          wdata_next = ram_data_i;
          cnt_next   = 8'd0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Error beats ack, and ack beats a timeout expiring in the same cycle.
        if (bus_err_i || (!bus_ack_i && cnt_reg == CNT_LAST)) begin
          rdata_next    = ERR_DATA;
          err_flag_next = 1'b1;
          sticky_next   = 1'b1;
          state_next    = HOLD;
        end else if (bus_ack_i) begin
          rdata_next    = we_reg ? 32'd0 : bus_rdata_i;
          err_flag_next = 1'b0;
          state_next    = HOLD;
        end else if (cnt_reg != 8'hFF) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus_req_o    = (state_reg == BUSY);
  assign bus_we_o     = we_reg;
  assign bus_sel_o    = sel_reg;
  assign bus_addr_o   = addr_reg;
  assign bus_wdata_o  = wdata_reg;
  assign ram_data_o   = (state_reg == HOLD) ? rdata_reg : 32'd0;
  assign err_o        = (state_reg == HOLD) && err_flag_reg;
  assign err_sticky_o = sticky_reg;
  assign stall_req_o  = ((state_reg == IDLE) && start) || (state_reg == BUSY);

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Multi-cycle data-memory bridge between the CPU's MEM-stage RAM port and an external word-wide request/acknowledge bus. It latches one load or store per access, holds the bus request until the slave acknowledges, errors out or times out, and stalls the pipeline meanwhile. It returns the raw 32-bit read word to MEM; byte extraction and sign extension stay in MEM.

## Interface
Parameters:
- TIMEOUT, 16: maximum BUSY cycles without ack/err before abort; legal range 2..255.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on bus error or timeout.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
- ram_ce_i  in  1  CPU access request (MEM stage)
- ram_we_i  in  1  1 = store, 0 = load
- ram_sel_i  in  4  byte lanes; bit n selects data[8n+7:8n]
- ram_addr_i  in  32  byte address
- ram_data_i  in  32  store data
- ram_data_o  out  32  load data to MEM
- stall_req_o  out  1  pipeline stall request
- err_o  out  1  one-cycle pulse: access ended by bus_err_i or timeout
- err_sticky_o  out  1  set by any error, cleared only by reset
- bus_req_o  out  1  bus request, held until ack/err/timeout
- bus_we_o  out  1  latched ram_we_i
- bus_sel_o  out  4  latched ram_sel_i
- bus_addr_o  out  32  latched {ram_addr_i[31:2], 2'b00}
- bus_wdata_o  out  32  latched ram_data_i
- bus_ack_i  in  1  slave completion
- bus_rdata_i  in  32  slave read data, valid with bus_ack_i
- bus_err_i  in  1  slave error, completes the access

## Operation
- States: IDLE, BUSY, HOLD.
- IDLE: if ram_ce_i=1 and ram_sel_i!=0, latch we/sel/word-address/wdata into the bus registers, clear the timeout counter, go to BUSY. ram_ce_i=1 with ram_sel_i=0 is a no-op: no stall, stay IDLE, ram_data_o=0.
- BUSY: bus_req_o=1; bus outputs stable. Per cycle, priority: bus_err_i, then bus_ack_i, then timeout.
  - bus_err_i=1: rdata register <= ERR_DATA, error flag set, go HOLD.
  - bus_ack_i=1: rdata register <= bus_rdata_i for loads, 0 for stores, go HOLD.
  - else if counter = TIMEOUT-1: treat as error (ERR_DATA, error flag), go HOLD; else counter+1.
- HOLD: bus_req_o=0; ram_data_o = rdata register; err_o = error flag; stall_req_o=0 so the pipeline advances at the end of this cycle; ram_ce_i ignored; unconditionally go IDLE.
- stall_req_o = (IDLE and ram_ce_i and ram_sel_i!=0) or BUSY (combinational on the IDLE term).
- ram_data_o = 0 outside HOLD.
- bus_ack_i/bus_err_i outside BUSY are ignored.
- err_sticky_o set on the HOLD entry that carries an error.
- Counter is 8 bits and saturates; no wrap-around is reachable within the legal TIMEOUT range.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counter 0, all latched bus registers 0, rdata 0, error flags 0. Hence bus_req_o=0, bus_we_o=0, bus_sel_o=0, bus_addr_o=0, bus_wdata_o=0, ram_data_o=0, err_o=0, err_sticky_o=0. stall_req_o=0 only while ram_ce_i=0.
- Reset during BUSY aborts the access: bus_req_o drops the moment rst goes low, no HOLD cycle, and no err_o pulse.
- Cycle 0 (IDLE, request): stall_req_o=1 combinationally, bus_req_o=0.
- Cycle 1..k (BUSY): bus_req_o=1, stall_req_o=1. Ack sampled in cycle k.
- Cycle k+1 (HOLD): ram_data_o valid, stall_req_o=0. Cycle k+2 is IDLE and a new request may start there.
- Minimum access (ack in first BUSY cycle): 3 cycles, 2 stalled.
- Timeout with no ack: BUSY lasts exactly TIMEOUT cycles, then HOLD.
- Back-to-back accesses: one IDLE cycle between HOLD and the next BUSY; bus_req_o is low for at least 2 cycles between accesses.
- Simultaneous bus_ack_i and bus_err_i: error wins.
- An ack in the same cycle the timeout expires: the ack wins, no error.

## Test plan
- Load, ack in first BUSY cycle: ram_addr_i=0x0000_1006, sel=4'b1111, bus_rdata_i=0x1234_5678. Expect bus_addr_o=0x0000_1004; stall high for 2 cycles; HOLD ram_data_o=0x1234_5678; err_o=0.
- Store, ack after 4 BUSY cycles: sel=4'b0011, ram_data_i=0xCAFE_F00D. Expect bus_we_o=1, bus_sel_o=0011, bus_wdata_o=0xCAFE_F00D stable for 4 cycles; stall 5 cycles; HOLD ram_data_o=0.
- Timeout with TIMEOUT=16 and no ack: expect exactly 16 BUSY cycles, then HOLD with ram_data_o=0xDEAD_BEEF, a single-cycle err_o pulse, and err_sticky_o=1 persisting.
- Ack and err in the same cycle: expect the error path (ERR_DATA, err_o=1). Also a stray ack in IDLE: expect no state change.
- Two back-to-back loads with ram_ce_i held high: expect the sequence IDLE, BUSY, HOLD, IDLE, BUSY, HOLD, each HOLD returning its own bus_rdata_i. Also ram_ce_i=1 with sel=0: expect no stall and no bus_req_o.
- rst pulled low mid-BUSY (async, between edges): expect bus_req_o=0 immediately, no err_o, err_sticky_o=0, and a clean new access after release.
